// File: rtl/sync_fifo_ram_pkg.sv
// Shared defaults and width helper for the sync_fifo_ram FIFO slice.
package sync_fifo_ram_pkg;

  localparam int DEF_SIZE  = 8;
  localparam int DEF_DEPTH = 16;

  // Occupancy counter must hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram_if.sv
// Handshake bundle between a producer/consumer (master) and the FIFO (slave).
interface sync_fifo_ram_if
  import sync_fifo_ram_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = cnt_w(DEPTH);

  logic [SIZE-1:0] din;
  logic            put;
  logic [SIZE-1:0] dout;
  logic            dout_valid;
  logic            get;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic            overflow;
  logic            underflow;

  modport master (
    output din, put, get,
    input  dout, dout_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  din, put, get,
    output dout, dout_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram_store.sv
// Simple dual-port storage with registered read and no reset so it maps onto block RAM.
module fifo_store_ram #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SIZE-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [SIZE-1:0]          rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock first-word-fall-through FIFO: pointers, occupancy and flags around a block-RAM store.
module sync_fifo_ram
  import sync_fifo_ram_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AFULL  = DEPTH - 2,
  parameter int AEMPTY = 1
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_ram_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wptr_p1, rptr_p1;
  logic [CW-1:0] count_p1;
  logic          full_p1, empty_p1, afull_p1, aempty_p1;
  logic          vld_p1, ovf_p1, udf_p1;

  logic          wr, rd;
  logic [AW-1:0] raddr;
  logic [CW-1:0] count_next;

  // Request qualification uses registered flags only.
  assign wr         = bus.put & ~full_p1;
  assign rd         = bus.get & vld_p1;
  assign raddr      = rd ? rptr_p1 + AW'(1) : rptr_p1;
  assign count_next = count_p1 + CW'(wr) - CW'(rd);

  fifo_store_ram #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_store (
    .clk   (clk),
    .we    (wr),
    .waddr (wptr_p1),
    .wdata (bus.din),
    .raddr (raddr),
    .rdata (bus.dout)
  );

  // Control state registered on the same edge as the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_p1   <= '0;
      rptr_p1   <= '0;
      count_p1  <= '0;
      full_p1   <= 1'b0;
      empty_p1  <= 1'b1;
      afull_p1  <= 1'b0;
      aempty_p1 <= 1'b1;
      vld_p1    <= 1'b0;
      ovf_p1    <= 1'b0;
      udf_p1    <= 1'b0;
    end else begin
      wptr_p1   <= wptr_p1 + AW'(wr);
      rptr_p1   <= rptr_p1 + AW'(rd);
      count_p1  <= count_next;
      full_p1   <= (count_next == CW'(DEPTH));
      empty_p1  <= (count_next == '0);
      afull_p1  <= (count_next >= CW'(AFULL));
      aempty_p1 <= (count_next <= CW'(AEMPTY));
      // A word written this edge is not readable until the next one.
      vld_p1    <= ((count_p1 - CW'(rd)) != '0);
      ovf_p1    <= bus.put & full_p1;
      udf_p1    <= bus.get & ~vld_p1;
    end
  end

  assign bus.count        = count_p1;
  assign bus.full         = full_p1;
  assign bus.empty        = empty_p1;
  assign bus.almost_full  = afull_p1;
  assign bus.almost_empty = aempty_p1;
  assign bus.dout_valid   = vld_p1;
  assign bus.overflow     = ovf_p1;
  assign bus.underflow    = udf_p1;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed and scoreboard bench for sync_fifo_ram with DEPTH=16, SIZE=8.
module tb_sync_fifo_ram;

  localparam int SIZE  = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sync_fifo_ram_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

  sync_fifo_ram #(.SIZE(SIZE), .DEPTH(DEPTH), .AFULL(14), .AEMPTY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.put = 1'b0;
    bus.get = 1'b0;
    bus.din = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
      checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", bus.almost_empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
      checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", bus.almost_full); end
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", bus.dout_valid); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {bus.overflow, bus.underflow}); end
      step();
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      bus.din = 8'(i + 1);
      bus.put = 1'b1;
      step();
      checks++; if (bus.count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i + 1); end
      checks++; if (bus.almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_afull n=%0d got=%b exp=%b", i + 1, bus.almost_full, (i + 1 >= 14)); end
      checks++; if (bus.full !== (i + 1 == DEPTH)) begin errors++; $display("FAIL fill_full n=%0d got=%b exp=%b", i + 1, bus.full, (i + 1 == DEPTH)); end
    end
    bus.put = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL drain_dv i=%0d got=%b exp=1", i, bus.dout_valid); end
      checks++; if (bus.dout !== 8'(i + 1)) begin errors++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, bus.dout, 8'(i + 1)); end
      bus.get = 1'b1;
      step();
    end
    bus.get = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL drain_dv_end got=%b exp=0", bus.dout_valid); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_latency();
    bus.din = 8'hA5;
    bus.put = 1'b1;
    step();
    bus.put = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL lat_dv_e0 got=%b exp=0", bus.dout_valid); end
    step();
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL lat_dv_e1 got=%b exp=1", bus.dout_valid); end
    checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL lat_dout got=%h exp=a5", bus.dout); end
    bus.get = 1'b1;
    step();
    bus.get = 1'b0;
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL lat_dv_pop got=%b exp=0", bus.dout_valid); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL lat_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      bus.din = 8'(8'h30 + i);
      bus.put = 1'b1;
      step();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", bus.full); end
    bus.din = 8'h77;
    bus.put = 1'b1;
    bus.get = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", bus.overflow); end
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL ovf_count got=%0d exp=15", bus.count); end
    step();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got=%b exp=0", bus.overflow); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      checks++; if (bus.dout !== 8'(8'h31 + i) || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain i=%0d got=%h/%b exp=%h/1", i, bus.dout, bus.dout_valid, 8'(8'h31 + i)); end
      bus.get = 1'b1;
      step();
    end
    bus.get = 1'b0;
    checks++; if (bus.empty !== 1'b1 || bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ovf_lost got empty=%b dv=%b exp 1/0", bus.empty, bus.dout_valid); end
  endtask

  task automatic test_underflow();
    bus.get = 1'b1;
    step();
    bus.get = 1'b0;
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got=%b exp=1", bus.underflow); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL udf_count got=%0d exp=0", bus.count); end
    step();
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL udf_pulse_end got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    for (int i = 0; i < 5; i++) begin
      bus.din = 8'(8'h50 + i);
      bus.put = 1'b1;
      q.push_back(8'(8'h50 + i));
      step();
    end
    bus.put = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== q[0]) begin errors++; $display("FAIL b2b_head k=%0d got=%h/%b exp=%h/1", k, bus.dout, bus.dout_valid, q[0]); end
      bus.din = 8'(8'h60 + k);
      bus.put = 1'b1;
      bus.get = 1'b1;
      void'(q.pop_front());
      q.push_back(8'(8'h60 + k));
      step();
      checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL b2b_count k=%0d got=%0d exp=5", k, bus.count); end
    end
    bus.put = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== q[0]) begin errors++; $display("FAIL b2b_drain i=%0d got=%h/%b exp=%h/1", i, bus.dout, bus.dout_valid, q[0]); end
      bus.get = 1'b1;
      void'(q.pop_front());
      step();
    end
    bus.get = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic       dvm = 1'b0;
    logic       p, g, wrm, rdm, fullb;
    int         sz, pp, gp;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      pp = ((cyc / 300) % 2 == 0) ? 75 : 30;
      gp = ((cyc / 300) % 2 == 0) ? 30 : 75;
      p  = ($urandom_range(0, 99) < pp);
      g  = ($urandom_range(0, 99) < gp);
      bus.din = 8'($urandom);
      bus.put = p;
      bus.get = g;
      sz    = q.size();
      fullb = (sz == DEPTH);
      wrm   = p && !fullb;
      rdm   = g && dvm;
      if (rdm) void'(q.pop_front());
      if (wrm) q.push_back(bus.din);
      step();
      checks++; if (bus.overflow !== (p && fullb)) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, bus.overflow, (p && fullb)); end
      checks++; if (bus.underflow !== (g && !dvm)) begin errors++; $display("FAIL rnd_udf cyc=%0d got=%b exp=%b", cyc, bus.underflow, (g && !dvm)); end
      dvm = ((sz - int'(rdm)) != 0);
      checks++; if (bus.dout_valid !== dvm) begin errors++; $display("FAIL rnd_dv cyc=%0d got=%b exp=%b", cyc, bus.dout_valid, dvm); end
      checks++; if (bus.count !== 5'(q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.count, q.size()); end
      checks++;
      if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty} !==
          {q.size() == DEPTH, q.size() == 0, q.size() >= 14, q.size() <= 1}) begin
        errors++;
        $display("FAIL rnd_flags cyc=%0d got=%b size=%0d", cyc,
                 {bus.full, bus.empty, bus.almost_full, bus.almost_empty}, q.size());
      end
      if (dvm) begin
        checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", cyc, bus.dout, q[0]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.din = 8'(8'h90 + i);
      bus.put = 1'b1;
      step();
    end
    checks++; if (bus.count !== 5'd9) begin errors++; $display("FAIL mid_count_pre got=%0d exp=9", bus.count); end
    rst = 1'b1;
    bus.put = 1'b1;
    bus.get = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", bus.count); end
    checks++;
    if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.dout_valid, bus.overflow, bus.underflow} !== 7'b0101000) begin
      errors++;
      $display("FAIL mid_flags got=%b exp=0101000",
               {bus.full, bus.empty, bus.almost_full, bus.almost_empty, bus.dout_valid, bus.overflow, bus.underflow});
    end
    step();
    step();
    checks++; if (bus.dout_valid !== 1'b0 || bus.count !== 5'd0) begin errors++; $display("FAIL mid_after got dv=%b count=%0d exp 0/0", bus.dout_valid, bus.count); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_latency();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
